uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter among `NUM_REQ` byte-stream requesters using round-robin arbitration.
- Once granted, a requester keeps the transmitter for a whole packet (up to a `last` byte), or until a configurable burst limit is reached.
- It sequences the transmitter's start/busy handshake and sits between the command/telemetry sources and the UART TX serializer.
- It is the transmit-side counterpart of the UART receive path.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_tx_arbiter_if.sv | 27 ++
 rtl/rr_pick.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 136 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encodings, one-hot decode and
// word-width limits used by the RX/TX blocks.
package uart_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_XFER  = 2'd1;
    localparam logic [1:0] ST_START = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    typedef enum logic [1:0] {
        StIdle  = ST_IDLE,
        StXfer  = ST_XFER,
        StStart = ST_START,
        StDrain = ST_DRAIN
    } arb_state_e;

    localparam int unsigned DATA_BITS_MIN = 5;
    localparam int unsigned DATA_BITS_MAX = 9;

    function automatic logic [7:0] onehot_dec(input logic [2:0] idx);
        onehot_dec = 8'b1 << idx;
    endfunction

    // Smallest width (at least 1) that can hold max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        cnt_width = 1;
        for (int i = 1; i < 32; i++) begin
            if ((max_val >> i) != 0) cnt_width = i + 1;
        end
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter handshake bundle for the UART TX arbiter.
// Member names are seen from the arbiter side (i_ = into arbiter).
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned IDX_BITS  = 2,
    parameter int unsigned DATA_BITS = 8
);
    logic [NUM_REQ-1:0]           i_req_valid;
    logic [NUM_REQ*DATA_BITS-1:0] i_req_data;
    logic [NUM_REQ-1:0]           i_req_last;
    logic [NUM_REQ-1:0]           o_req_ready;
    logic                         o_tx_start;
    logic [DATA_BITS-1:0]         o_tx_data;
    logic                         i_tx_busy;
    logic                         o_grant_valid;
    logic [IDX_BITS-1:0]          o_grant_idx;

    modport master (
        input  i_req_valid, i_req_data, i_req_last, i_tx_busy,
        output o_req_ready, o_tx_start, o_tx_data, o_grant_valid, o_grant_idx
    );

    modport slave (
        output i_req_valid, i_req_data, i_req_last, i_tx_busy,
        input  o_req_ready, o_tx_start, o_tx_data, o_grant_valid, o_grant_idx
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned IDX_BITS = 2
) (
    input  logic [NUM_REQ-1:0]  i_req,
    input  logic [IDX_BITS-1:0] i_ptr,
    output logic                o_found,
    output logic [IDX_BITS-1:0] o_idx
);
    localparam int unsigned PAD_W = 2 ** IDX_BITS;

    logic [PAD_W-1:0]  w_req_pad;
    logic [IDX_BITS:0] w_sum;

    // Scan offsets from far to near so the nearest hit is assigned last.
    always_comb begin
        w_req_pad              = '0;
        w_req_pad[NUM_REQ-1:0] = i_req;
        w_sum                  = '0;
        o_found                = 1'b0;
        o_idx                  = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            w_sum = {1'b0, i_ptr} + (IDX_BITS + 1)'(off);
            if (w_sum >= (IDX_BITS + 1)'(NUM_REQ)) w_sum = w_sum - (IDX_BITS + 1)'(NUM_REQ);
            if (w_req_pad[w_sum[IDX_BITS-1:0]]) begin
                o_found = 1'b1;
                o_idx   = w_sum[IDX_BITS-1:0];
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-atomic sharing of one UART transmitter among NUM_REQ
// byte-stream requesters, with optional burst limit per grant.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned IDX_BITS  = 2,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    uart_tx_arbiter_if.master io_bus
);
    localparam int unsigned BURST_W = cnt_width(MAX_BURST);

    arb_state_e           r_state, w_state_d;
    logic [IDX_BITS-1:0]  r_ptr, w_ptr_d;
    logic [IDX_BITS-1:0]  r_owner, w_owner_d;
    logic [BURST_W-1:0]   r_burst, w_burst_d;
    logic                 r_last, w_last_d;
    logic                 r_grant_valid, w_grant_d;
    logic [DATA_BITS-1:0] r_tx_data, w_tx_data_d;

    logic                 w_found;
    logic [IDX_BITS-1:0]  w_pick;
    logic                 w_own_valid;
    logic                 w_own_last;
    logic [DATA_BITS-1:0] w_own_data;
    logic [7:0]           w_onehot;
    logic                 w_burst_done;
    logic [IDX_BITS-1:0]  w_ptr_next;

    rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .IDX_BITS (IDX_BITS)
    ) u_rr_pick (
        .i_req   (io_bus.i_req_valid),
        .i_ptr   (r_ptr),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    always_comb begin
        w_own_valid = 1'b0;
        w_own_last  = 1'b0;
        w_own_data  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r_owner == IDX_BITS'(k)) begin
                w_own_valid = io_bus.i_req_valid[k];
                w_own_last  = io_bus.i_req_last[k];
                w_own_data  = io_bus.i_req_data[k*DATA_BITS +: DATA_BITS];
            end
        end
    end

    if (MAX_BURST == 0) begin : g_unlimited
        assign w_burst_done = 1'b0;
    end else begin : g_limited
        assign w_burst_done = (r_burst == BURST_W'(MAX_BURST));
    end

    assign w_ptr_next = (r_owner == IDX_BITS'(NUM_REQ - 1)) ? '0 : r_owner + IDX_BITS'(1);
    assign w_onehot   = onehot_dec(3'(r_owner));

    // Ready depends only on state, owner and busy, never on valid.
    assign io_bus.o_req_ready   = (r_state == StXfer && !io_bus.i_tx_busy) ?
                                  w_onehot[NUM_REQ-1:0] : '0;
    assign io_bus.o_tx_start    = (r_state == StStart);
    assign io_bus.o_tx_data     = r_tx_data;
    assign io_bus.o_grant_valid = r_grant_valid;
    assign io_bus.o_grant_idx   = r_owner;

    always_comb begin
        w_state_d   = r_state;
        w_ptr_d     = r_ptr;
        w_owner_d   = r_owner;
        w_burst_d   = r_burst;
        w_last_d    = r_last;
        w_grant_d   = r_grant_valid;
        w_tx_data_d = r_tx_data;
        unique case (r_state)
            StIdle: begin
                if (w_found) begin
                    w_owner_d = w_pick;
                    w_burst_d = '0;
                    w_grant_d = 1'b1;
                    w_state_d = StXfer;
                end
            end
            StXfer: begin
                if (w_own_valid && !io_bus.i_tx_busy) begin
                    w_tx_data_d = w_own_data;
                    w_last_d    = w_own_last;
                    w_burst_d   = r_burst + BURST_W'(1);
                    w_state_d   = StStart;
                end
            end
            StStart: begin
                w_state_d = StDrain;
            end
            StDrain: begin
                if (!io_bus.i_tx_busy) begin
                    if (r_last || w_burst_done) begin
                        w_ptr_d   = w_ptr_next;
                        w_grant_d = 1'b0;
                        w_state_d = StIdle;
                    end else begin
                        w_state_d = StXfer;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state       <= StIdle;
            r_ptr         <= '0;
            r_owner       <= '0;
            r_burst       <= '0;
            r_last        <= 1'b0;
            r_grant_valid <= 1'b0;
            r_tx_data     <= '0;
        end else begin
            r_state       <= w_state_d;
            r_ptr         <= w_ptr_d;
            r_owner       <= w_owner_d;
            r_burst       <= w_burst_d;
            r_last        <= w_last_d;
            r_grant_valid <= w_grant_d;
            r_tx_data     <= w_tx_data_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: three instances (default, burst limit 2,
// three requesters) driven by word queues and a counting transmitter model.
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Per-instance stimulus and observation (index 0: A, 1: B, 2: C)
    logic [3:0]  valid_v  [3];
    logic [3:0]  last_v   [3];
    logic [31:0] data_v   [3];
    logic [3:0]  ready_v  [3];
    logic        start_v  [3];
    logic [7:0]  txd_v    [3];
    logic        gvalid_v [3];
    logic [1:0]  gidx_v   [3];
    logic        busy_v   [3];
    logic [3:0]  hs       [3] = '{default: '0};
    logic [3:0]  en       [3] = '{default: '0};
    logic        force_busy [3] = '{default: 1'b0};
    int          busy_cnt [3] = '{0, 0, 0};
    int          blen     [3] = '{10, 3, 2};
    logic [8:0]  sq   [3][4][$];
    logic [9:0]  slog [3][$];

    uart_tx_arbiter_if #(.NUM_REQ(4), .IDX_BITS(2), .DATA_BITS(8)) ifa ();
    uart_tx_arbiter_if #(.NUM_REQ(4), .IDX_BITS(2), .DATA_BITS(8)) ifb ();
    uart_tx_arbiter_if #(.NUM_REQ(3), .IDX_BITS(2), .DATA_BITS(8)) ifc ();

    uart_tx_arbiter #(.NUM_REQ(4), .IDX_BITS(2), .DATA_BITS(8), .MAX_BURST(16)) dut_a (
        .i_Clk (clk), .i_Rst_n (rst_n), .io_bus (ifa));
    uart_tx_arbiter #(.NUM_REQ(4), .IDX_BITS(2), .DATA_BITS(8), .MAX_BURST(2)) dut_b (
        .i_Clk (clk), .i_Rst_n (rst_n), .io_bus (ifb));
    uart_tx_arbiter #(.NUM_REQ(3), .IDX_BITS(2), .DATA_BITS(8), .MAX_BURST(16)) dut_c (
        .i_Clk (clk), .i_Rst_n (rst_n), .io_bus (ifc));

    for (genvar g = 0; g < 3; g++) begin : g_busy
        assign busy_v[g] = (busy_cnt[g] != 0) || force_busy[g];
    end

    assign ifa.i_req_valid = valid_v[0];
    assign ifa.i_req_data  = data_v[0];
    assign ifa.i_req_last  = last_v[0];
    assign ifa.i_tx_busy   = busy_v[0];
    assign ready_v[0]  = ifa.o_req_ready;
    assign start_v[0]  = ifa.o_tx_start;
    assign txd_v[0]    = ifa.o_tx_data;
    assign gvalid_v[0] = ifa.o_grant_valid;
    assign gidx_v[0]   = ifa.o_grant_idx;

    assign ifb.i_req_valid = valid_v[1];
    assign ifb.i_req_data  = data_v[1];
    assign ifb.i_req_last  = last_v[1];
    assign ifb.i_tx_busy   = busy_v[1];
    assign ready_v[1]  = ifb.o_req_ready;
    assign start_v[1]  = ifb.o_tx_start;
    assign txd_v[1]    = ifb.o_tx_data;
    assign gvalid_v[1] = ifb.o_grant_valid;
    assign gidx_v[1]   = ifb.o_grant_idx;

    assign ifc.i_req_valid = valid_v[2][2:0];
    assign ifc.i_req_data  = data_v[2][23:0];
    assign ifc.i_req_last  = last_v[2][2:0];
    assign ifc.i_tx_busy   = busy_v[2];
    assign ready_v[2]  = {1'b0, ifc.o_req_ready};
    assign start_v[2]  = ifc.o_tx_start;
    assign txd_v[2]    = ifc.o_tx_data;
    assign gvalid_v[2] = ifc.o_grant_valid;
    assign gidx_v[2]   = ifc.o_grant_idx;

    // Handshake capture, start log and transmitter busy model
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            hs[d] <= valid_v[d] & ready_v[d];
            if (start_v[d]) begin
                slog[d].push_back({gidx_v[d], txd_v[d]});
                busy_cnt[d] <= blen[d];
            end else if (busy_cnt[d] > 0) begin
                busy_cnt[d] <= busy_cnt[d] - 1;
            end
        end
    end

    task automatic cyc();
        logic [8:0] h;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 4; k++) begin
                if (hs[d][k] && sq[d][k].size() != 0) void'(sq[d][k].pop_front());
                if (en[d][k] && sq[d][k].size() != 0) begin
                    h = sq[d][k][0];
                    valid_v[d][k]        = 1'b1;
                    data_v[d][k*8 +: 8]  = h[7:0];
                    last_v[d][k]         = h[8];
                end else begin
                    valid_v[d][k] = 1'b0;
                    last_v[d][k]  = 1'b0;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_log(input int d, input int pos, input logic [1:0] idx,
                           input logic [7:0] data, input string name);
        logic [31:0] act;
        act = (pos < slog[d].size()) ? {22'd0, slog[d][pos]} : 32'hdead;
        chk(name, act, {22'd0, idx, data});
    endtask

    task automatic run_until_log(input int d, input int n, input int budget, input string name);
        int c = 0;
        while (slog[d].size() < n && c < budget) begin
            cyc();
            c++;
        end
        chk(name, slog[d].size(), n);
    endtask

    task automatic wait_release(input int d, input int budget, input string name);
        int c = 0;
        while (gvalid_v[d] && c < budget) begin
            cyc();
            c++;
        end
        chk(name, {31'd0, gvalid_v[d]}, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            en[d] = '0;
            for (int k = 0; k < 4; k++) sq[d][k].delete();
        end
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        for (int d = 0; d < 3; d++) slog[d].delete();
    endtask

    typedef struct packed {
        logic [3:0] mask;
        logic [2:0] n;
        logic [7:0] ord;   // grant order, first entry in [1:0]
    } arb_vec_t;

    arb_vec_t tbl [5];

    initial begin
        int bad;
        int bad_rdy;
        logic [9:0] e6 [7];
        logic [1:0] oi;

        tbl[0] = '{4'b0101, 3'd2, {2'd0, 2'd0, 2'd2, 2'd0}};
        tbl[1] = '{4'b1111, 3'd4, {2'd2, 2'd1, 2'd0, 2'd3}};
        tbl[2] = '{4'b0110, 3'd2, {2'd0, 2'd0, 2'd2, 2'd1}};
        tbl[3] = '{4'b1001, 3'd2, {2'd0, 2'd0, 2'd0, 2'd3}};
        tbl[4] = '{4'b0010, 3'd1, {2'd0, 2'd0, 2'd0, 2'd1}};
        e6 = '{10'h3A1, 10'h3A2, 10'h001, 10'h002, 10'h3A3, 10'h3A4, 10'h3A5};

        for (int d = 0; d < 3; d++) begin
            valid_v[d] = '0;
            last_v[d]  = '0;
            data_v[d]  = '0;
        end
        rst_n = 1'b0;
        cyc();
        cyc();

        // Reset values
        chk("rst_ready", {28'd0, ready_v[0]}, 32'd0);
        chk("rst_start", {31'd0, start_v[0]}, 32'd0);
        chk("rst_txdata", {24'd0, txd_v[0]}, 32'd0);
        chk("rst_gvalid", {31'd0, gvalid_v[0]}, 32'd0);
        chk("rst_gidx", {30'd0, gidx_v[0]}, 32'd0);
        chk("rst_gvalid_b", {31'd0, gvalid_v[1]}, 32'd0);
        chk("rst_gvalid_c", {31'd0, gvalid_v[2]}, 32'd0);
        rst_n = 1'b1;
        cyc();

        // Single requester 1, two-word packet, exact first-transfer latency
        sq[0][1].push_back(9'h041);
        sq[0][1].push_back(9'h142);
        en[0] = 4'b0010;
        cyc();
        chk("lat_idle_gvalid", {31'd0, gvalid_v[0]}, 32'd0);
        cyc();
        chk("lat_grant_valid", {31'd0, gvalid_v[0]}, 32'd1);
        chk("lat_grant_idx", {30'd0, gidx_v[0]}, 32'd1);
        chk("lat_ready", {28'd0, ready_v[0]}, 32'h2);
        cyc();
        chk("lat_start", {31'd0, start_v[0]}, 32'd1);
        chk("lat_txdata", {24'd0, txd_v[0]}, 32'h41);
        chk("lat_ready_start", {28'd0, ready_v[0]}, 32'd0);
        cyc();
        chk("lat_start_single", {31'd0, start_v[0]}, 32'd0);
        bad = 0;
        for (int c = 0; c < 100 && slog[0].size() < 2; c++) begin
            cyc();
            if (!gvalid_v[0] || gidx_v[0] != 2'd1) bad++;
        end
        chk("pkt_two_starts", slog[0].size(), 2);
        chk("pkt_grant_hold", bad, 0);
        for (int c = 0; c < 50 && busy_v[0]; c++) cyc();
        chk("pkt_hold_at_busy_fall", {31'd0, gvalid_v[0]}, 32'd1);
        cyc();
        chk("pkt_release", {31'd0, gvalid_v[0]}, 32'd0);
        chk_log(0, 0, 2'd1, 8'h41, "pkt_word0");
        chk_log(0, 1, 2'd1, 8'h42, "pkt_word1");

        // Arbitration order table, starting from ptr 0
        do_reset();
        for (int r = 0; r < 5; r++) begin
            slog[0].delete();
            for (int k = 0; k < 4; k++) begin
                if (tbl[r].mask[k]) sq[0][k].push_back({1'b1, 8'(16 * r + k)});
            end
            en[0] = tbl[r].mask;
            run_until_log(0, int'(tbl[r].n), 300, $sformatf("tbl%0d_count", r));
            for (int i = 0; i < int'(tbl[r].n); i++) begin
                oi = tbl[r].ord[2*i +: 2];
                chk_log(0, i, oi, 8'(16 * r + int'(oi)), $sformatf("tbl%0d_e%0d", r, i));
            end
            wait_release(0, 50, $sformatf("tbl%0d_release", r));
        end

        // Owner 0 stalls mid-packet; requester 1 must not preempt
        do_reset();
        sq[0][0].push_back(9'h030);
        sq[0][0].push_back(9'h031);
        sq[0][0].push_back(9'h132);
        sq[0][1].push_back(9'h1A0);
        en[0] = 4'b0011;
        run_until_log(0, 1, 50, "stall_first");
        en[0] = 4'b0010;
        bad = 0;
        bad_rdy = 0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            if (!gvalid_v[0] || gidx_v[0] != 2'd0) bad++;
            if (ready_v[0][1]) bad_rdy++;
        end
        chk("stall_grant_hold", bad, 0);
        chk("stall_ready1_low", bad_rdy, 0);
        chk("stall_no_words", slog[0].size(), 1);
        en[0] = 4'b0011;
        run_until_log(0, 4, 200, "stall_resume");
        chk_log(0, 0, 2'd0, 8'h30, "stall_w0");
        chk_log(0, 1, 2'd0, 8'h31, "stall_w1");
        chk_log(0, 2, 2'd0, 8'h32, "stall_w2");
        chk_log(0, 3, 2'd1, 8'hA0, "stall_w3");
        wait_release(0, 50, "stall_release");

        // Reset asserted during DRAIN with the transmitter still busy
        slog[0].delete();
        sq[0][2].push_back(9'h155);
        en[0] = 4'b0100;
        run_until_log(0, 1, 50, "rstmid_start");
        force_busy[0] = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rstmid_gvalid", {31'd0, gvalid_v[0]}, 32'd0);
        chk("rstmid_gidx", {30'd0, gidx_v[0]}, 32'd0);
        chk("rstmid_start_low", {31'd0, start_v[0]}, 32'd0);
        chk("rstmid_ready", {28'd0, ready_v[0]}, 32'd0);
        chk("rstmid_txdata", {24'd0, txd_v[0]}, 32'd0);
        cyc();
        cyc();
        rst_n = 1'b1;
        slog[0].delete();
        sq[0][1].push_back(9'h1B1);
        sq[0][3].push_back(9'h1B3);
        en[0] = 4'b1010;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            cyc();
            if (ready_v[0] != 4'd0) bad++;
        end
        chk("rstmid_no_ready_busy", bad, 0);
        chk("rstmid_no_start", slog[0].size(), 0);
        chk("rstmid_grant_ptr0", {29'd0, gvalid_v[0], gidx_v[0]}, 32'h5);
        force_busy[0] = 1'b0;
        run_until_log(0, 2, 200, "rstmid_resume");
        chk_log(0, 0, 2'd1, 8'hB1, "rstmid_w0");
        chk_log(0, 1, 2'd3, 8'hB3, "rstmid_w1");

        // Burst limit 2: requester 3 five-word packet interleaved with 0
        for (int i = 0; i < 5; i++) sq[1][3].push_back({(i == 4), 8'(8'hA1 + i)});
        sq[1][0].push_back(9'h001);
        sq[1][0].push_back(9'h102);
        en[1] = 4'b1000;
        for (int c = 0; c < 10 && !gvalid_v[1]; c++) cyc();
        chk("burst_grant3", {29'd0, gvalid_v[1], gidx_v[1]}, 32'h7);
        en[1] = 4'b1001;
        run_until_log(1, 7, 400, "burst_count");
        for (int i = 0; i < 7; i++) chk_log(1, i, e6[i][9:8], e6[i][7:0], $sformatf("burst_e%0d", i));

        // Three requesters: wrap from index 2 back to 0
        sq[2][1].push_back(9'h1C1);
        en[2] = 4'b0111;
        run_until_log(2, 1, 50, "wrap_first");
        wait_release(2, 50, "wrap_rel1");
        sq[2][2].push_back(9'h1C2);
        run_until_log(2, 2, 50, "wrap_second");
        wait_release(2, 50, "wrap_rel2");
        sq[2][0].push_back(9'h1C0);
        sq[2][1].push_back(9'h1C3);
        run_until_log(2, 4, 100, "wrap_third");
        chk_log(2, 0, 2'd1, 8'hC1, "wrap_e0");
        chk_log(2, 1, 2'd2, 8'hC2, "wrap_e1");
        chk_log(2, 2, 2'd0, 8'hC0, "wrap_e2");
        chk_log(2, 3, 2'd1, 8'hC3, "wrap_e3");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
